// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The slave modport is the unit itself; the master modport is the decoder/consumer side.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           func;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic [2:0]           out_func;
  logic                 zero;
  logic                 parity;
  logic [CNT_WIDTH-1:0] op_count;

  modport slave (
    input  flush, in_valid, a, b, func, out_ready,
    output in_ready, out_valid, result, out_func, zero, parity, op_count
  );

  modport master (
    output flush, in_valid, a, b, func, out_ready,
    input  in_ready, out_valid, result, out_func, zero, parity, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready backpressure,
// per-result zero/parity flags and a wrapping completed-operation counter.
module logic_unit_pipe #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  logic_unit_pipe_if.slave bus
);

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2:0]           r_func;

  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_result;
  logic [2:0]           r_out_func;
  logic                 r_zero;
  logic                 r_parity;
  logic [CNT_WIDTH-1:0] r_op_count;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_out_hs;
  logic [WIDTH-1:0]     w_res;

  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_s2_valid && bus.out_ready;

  always_comb begin
    w_res = '0;
    unique case (r_func)
      3'b000: w_res = r_a & r_b;
      3'b001: w_res = r_a | r_b;
      3'b010: w_res = ~(r_a & r_b);
      3'b011: w_res = ~(r_a | r_b);
      3'b100: w_res = r_a ^ r_b;
      3'b101: w_res = ~(r_a ^ r_b);
      3'b110: w_res = ~r_a;
      3'b111: w_res = r_a & ~r_b;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_func     <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_out_func <= '0;
      r_zero     <= 1'b0;
      r_parity   <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        r_a        <= bus.a;
        r_b        <= bus.b;
        r_func     <= bus.func;
      end
      // Flags only move with a real result so they hold while out_valid is low.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result   <= w_res;
          r_out_func <= r_func;
          r_zero     <= ~|w_res;
          r_parity   <= ^w_res;
        end
      end
      if (w_out_hs && !bus.flush) begin
        r_op_count <= r_op_count + 1'b1;
      end
      // Flush wins over any same-cycle handshake: both valids drop, data stays.
      if (bus.flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.result    = r_result;
  assign bus.out_func  = r_out_func;
  assign bus.zero      = r_zero;
  assign bus.parity    = r_parity;
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: expected results are queued at input
// acceptance and compared in order when the unit hands a result out.
module tb_logic_unit_pipe;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  logic_unit_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            passed = 0;
  int            total  = 0;
  logic [18:0]   sb[$];
  logic [18:0]   mon_e;
  logic [CW-1:0] exp_cnt = '0;

  function automatic logic [15:0] ref_op(input logic [2:0] f, input logic [15:0] x,
                                         input logic [15:0] y);
    logic [15:0] r;
    case (f)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = ~(x & y);
      3'd3:    r = ~(x | y);
      3'd4:    r = x ^ y;
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x & ~y;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Call only just after a rising edge; leaves in_valid high on return.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [2:0] f);
    bit acc = 1'b0;
    bus.a = x; bus.b = y; bus.func = f; bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
    end
    if (acc) sb.push_back({f, ref_op(f, x, y)});
    else begin
      total++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 &&
        bus.flush === 1'b0) begin
      if (sb.size() == 0) begin
        total++;
        $error("FAIL unexpected_out observed=%0h expected=none", bus.result);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", 64'(bus.result), 64'(mon_e[15:0]));
        check("out_func", 64'(bus.out_func), 64'(mon_e[18:16]));
        check("out_zero", 64'(bus.zero), 64'(mon_e[15:0] == 16'h0));
        check("out_parity", 64'(bus.parity), 64'(^mon_e[15:0]));
        exp_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] base;
    logic [CW-1:0] n;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.func = '0;
    bus.out_ready = 1'b0;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_out_func", 64'(bus.out_func), 64'(0));
    check("rst_zero", 64'(bus.zero), 64'(0));
    check("rst_parity", 64'(bus.parity), 64'(0));
    check("rst_op_count", 64'(bus.op_count), 64'(0));
    #6 rst = 1'b1;
    #1 check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;

    // Back-to-back, all eight functions.
    bus.out_ready = 1'b1;
    for (int f = 0; f < 8; f++) send(16'hF0F0, 16'hFF00, 3'(f));
    check("stream_inflight", 64'(sb.size()), 64'(2));
    bus.in_valid = 1'b0;
    drain();
    check("stream_count", 64'(bus.op_count), 64'(8));
    check("stream_idle", 64'(bus.out_valid), 64'(0));

    // Zero / parity flags and two-edge latency.
    send(16'h1234, 16'h1234, 3'd4);
    bus.in_valid = 1'b0;
    @(negedge clk); check("lat_edge1", 64'(bus.out_valid), 64'(0));
    @(negedge clk); check("lat_edge2", 64'(bus.out_valid), 64'(1));
    check("xor_zero", 64'(bus.zero), 64'(1));
    check("xor_parity", 64'(bus.parity), 64'(0));
    @(posedge clk); #1;
    send(16'h0001, 16'h0000, 3'd1);
    bus.in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("or_zero", 64'(bus.zero), 64'(0));
    check("or_parity", 64'(bus.parity), 64'(1));
    drain();

    // Backpressure: two beats fill the pipe, the third waits.
    base = exp_cnt;
    bus.out_ready = 1'b0;
    send(16'hA5A5, 16'h0F0F, 3'd0);
    send(16'hA5A5, 16'h0F0F, 3'd4);
    bus.a = 16'h3C3C; bus.b = 16'h00FF; bus.func = 3'd7; bus.in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      check("stall_valid", 64'(bus.out_valid), 64'(1));
      check("stall_result", 64'(bus.result), 64'(16'h0505));
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk); check("release_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    sb.push_back({3'd7, ref_op(3'd7, 16'h3C3C, 16'h00FF)});
    bus.in_valid = 1'b0;
    drain();
    check("bp_count", 64'(bus.op_count), 64'(base + 8'd3));

    // Flush with both stages full and the consumer stalled.
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 3'd1);
    send(16'h00F0, 16'h0F00, 3'd4);
    bus.a = 16'hFFFF; bus.b = 16'h0000; bus.func = 3'd0; bus.flush = 1'b1;
    @(negedge clk); check("flush_full_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_valid", 64'(bus.out_valid), 64'(0));
    check("flush_in_ready", 64'(bus.in_ready), 64'(1));
    check("flush_count", 64'(bus.op_count), 64'(exp_cnt));
    check("flush_data_kept", 64'(bus.result), 64'(16'h3333));
    @(posedge clk); #1;
    // A beat accepted in the flush cycle is dropped.
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk); check("flush_hs_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("flush_dropped", 64'(bus.out_valid), 64'(0));
    end
    check("flush_count2", 64'(bus.op_count), 64'(exp_cnt));
    @(posedge clk); #1;

    // Counter wrap.
    n = 8'hFF - exp_cnt;
    for (int i = 0; i < int'(n); i++)
      send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
    bus.in_valid = 1'b0;
    drain();
    check("cnt_max", 64'(bus.op_count), 64'(8'hFF));
    send(16'hBEEF, 16'h1234, 3'd5);
    bus.in_valid = 1'b0;
    drain();
    check("cnt_wrap", 64'(bus.op_count), 64'(0));

    // Asynchronous reset in the middle of a stall.
    bus.out_ready = 1'b0;
    send(16'h0001, 16'h0000, 3'd6);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'(0));
    check("arst_result", 64'(bus.result), 64'(0));
    check("arst_out_func", 64'(bus.out_func), 64'(0));
    check("arst_zero", 64'(bus.zero), 64'(0));
    check("arst_parity", 64'(bus.parity), 64'(0));
    check("arst_op_count", 64'(bus.op_count), 64'(0));
    sb.delete();
    exp_cnt = '0;
    @(negedge clk); #2 rst = 1'b1;
    #1 check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h00FF, 16'h0F0F, 3'd3);
    bus.in_valid = 1'b0;
    @(negedge clk); check("post_lat1", 64'(bus.out_valid), 64'(0));
    @(negedge clk); check("post_lat2", 64'(bus.out_valid), 64'(1));
    check("post_result", 64'(bus.result), 64'(16'hF000));
    drain();
    check("post_count", 64'(bus.op_count), 64'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
